fifo_ctrl: RTL
==============

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter DATA_W, default 4, data width in bits.
REQ-002 Parameter ADDR_W, default 3, RAM address width; depth = 2^ADDR_W (8).
REQ-003 Parameter AF_TH, default 6, almost_full threshold (count >= AF_TH).
REQ-004 Parameter AE_TH, default 2, almost_empty threshold (count <= AE_TH).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset_L  in  1  asynchronous, active-low reset.
REQ-007 push  in  1  write request; accepted only when full=0.
REQ-008 pop  in  1  read request; accepted only when empty=0.
REQ-009 data_in  in  DATA_W  write data, sampled with an accepted push.
REQ-010 data_out  out  DATA_W  read data; equals q_b.
REQ-011 valid  out  1  data_out holds popped word this cycle.
REQ-012 full / empty  out  1 each  count = depth / count = 0.
REQ-013 almost_full / almost_empty  out  1 each  threshold flags per REQ-003/004.
REQ-014 fifo_cnt  out  ADDR_W+1  current occupancy, 0..depth.
REQ-015 we_a, addr_a[ADDR_W], data_a[DATA_W]  out  RAM write port.
REQ-016 re_b, addr_b[ADDR_W]  out  RAM read port; q_b  in  DATA_W  RAM registered read data (1-cycle latency).
REQ-017 err_overflow, err_underflow  out  1 each  present only with FIFO_ERR_EN.

Function
REQ-018 Accepted push = push & ~full; accepted pop = pop & ~empty; both evaluated on registered count before the edge.
REQ-019 we_a SHALL equal accepted push combinationally; addr_a = wr_ptr; data_a = data_in.
REQ-020 re_b SHALL equal accepted pop combinationally; addr_b = rd_ptr.
REQ-021 wr_ptr / rd_ptr SHALL increment by 1 on accepted push / pop, wrapping 7 -> 0 (modulo depth).
REQ-022 fifo_cnt: +1 on push-only, -1 on pop-only, unchanged on both or neither.
REQ-023 valid SHALL be a register set to accepted pop of the previous cycle; data_out valid in that same cycle.
REQ-024 Push and pop while empty: push accepted, pop rejected (no fall-through); count becomes 1.
REQ-025 Push and pop while full: pop accepted, push rejected; count becomes depth-1.
REQ-026 Push and pop with 0 < count < depth: both accepted, count unchanged, pointers both advance.
REQ-027 Rejected requests SHALL not change pointers, count, or RAM strobes.
REQ-028 Flags full/empty/almost_* SHALL be combinational decodes of registered fifo_cnt.

Reset
REQ-029 reset_L=0 SHALL immediately clear wr_ptr, rd_ptr, fifo_cnt, valid (and error flags) independent of clk.
REQ-030 During reset: empty=1, almost_empty=1, full=0, almost_full=0, we_a=0, re_b=0, addr_a=addr_b=0.
REQ-031 Reset mid-operation SHALL discard all contents; RAM contents are not cleared, only made unreachable.
REQ-032 First push after reset_L release SHALL be accepted on the first rising edge.

Configuration
REQ-033 Macro FIFO_ERR_EN defined: err_overflow sets on push & full, err_underflow sets on pop & empty; both sticky until reset.
REQ-034 FIFO_ERR_EN undefined: error ports and logic absent; rejected requests silently ignored.

Verification
REQ-035 Reset, then push 4'h1,4'h2,4'h3 at addr 0,1,2 -> fifo_cnt=3, empty=0, we_a pulses at addr_a 0,1,2.
REQ-036 Pop three times -> re_b with addr_b 0,1,2; valid one cycle later each, data_out 1,2,3; empty=1 after third.
REQ-037 Push 9 words 0..8 back-to-back -> full after 8th, 9th push gives we_a=0, fifo_cnt=8; err_overflow=1 with FIFO_ERR_EN.
REQ-038 From count=8 push+pop same cycle -> only pop accepted, count=7; from count=0 push+pop -> only push, count=1.
REQ-039 Drive 12 push/pop pairs at count=4 -> pointers wrap 7->0, count stays 4, data order preserved.
REQ-040 Assert reset_L=0 between edges with count=5 -> fifo_cnt=0, empty=1, valid=0 without waiting for clk.

Source files
------------

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/occupancy controller for a FIFO built on an external RAM with 1-cycle read latency.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_EN is defined.
module fifo_ctrl #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 3,
   parameter int AF_TH  = 6,
   parameter int AE_TH  = 2
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   fifo_cnt,
   output logic              we_a,
   output logic [ADDR_W-1:0] addr_a,
   output logic [DATA_W-1:0] data_a,
   output logic              re_b,
   output logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] q_b
`ifdef FIFO_ERR_EN
   ,
   output logic              err_overflow,
   output logic              err_underflow
`endif
);

   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);
   localparam logic [ADDR_W:0] AF_C  = (ADDR_W+1)'(AF_TH);
   localparam logic [ADDR_W:0] AE_C  = (ADDR_W+1)'(AE_TH);

   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              push_ok, pop_ok;

   assign full         = (fifo_cnt == DEPTH);
   assign empty        = (fifo_cnt == '0);
   assign almost_full  = (fifo_cnt >= AF_C);
   assign almost_empty = (fifo_cnt <= AE_C);

   // Strobes are gated by reset_L so the RAM sees no access while reset is held.
   assign push_ok = push & ~full  & reset_L;
   assign pop_ok  = pop  & ~empty & reset_L;

   assign we_a     = push_ok;
   assign addr_a   = wr_ptr;
   assign data_a   = data_in;
   assign re_b     = pop_ok;
   assign addr_b   = rd_ptr;
   assign data_out = q_b;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         valid    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
         // q_b lands one cycle after re_b, so valid trails the accepted pop.
         valid <= pop_ok;
      end
   end

`ifdef FIFO_ERR_EN
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (push & full) err_overflow  <= 1'b1;
         if (pop & empty) err_underflow <= 1'b1;
      end
   end
`endif

endmodule
